prio_dec_2to4_buf: RTL and testbench

//  Receive end of the 4-to-2 priority-encoder interface: takes the encoded index
//  (q) plus its valid (v) and rebuilds the one-hot 4-bit request/grant vector.

---
 rtl/prio_pkg.sv | 23 ++
 rtl/prio_dec_2to4_buf_if.sv | 37 +++
 rtl/prio_idx_fifo.sv | 62 ++++++
 rtl/prio_dec_2to4_buf.sv | 65 ++++++
 tb/tb_prio_dec_2to4_buf.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/prio_pkg.sv
// ============================================================================
// Module      : prio_pkg
// Description : Index/one-hot widths and decode helper shared by both ends of
//               the 4-to-2 priority-encoder link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prio_pkg;

    localparam int IDX_W    = 2;
    localparam int ONEHOT_W = 4;

    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    function automatic onehot_t dec_idx(input idx_t idx);
        return onehot_t'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_dec_2to4_buf_if.sv
// ============================================================================
// Module      : prio_dec_2to4_buf_if
// Description : Encoder-side input, consumer handshake and debug status of
//               the buffered 2-to-4 decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prio_dec_2to4_buf_if
    import prio_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
);

    idx_t                   q;
    logic                   v;
    logic                   in_ready;
    onehot_t                y;
    logic                   y_valid;
    logic                   y_ready;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       drop_cnt;

    modport master (
        output q, v, y_ready,
        input  in_ready, y, y_valid, level, drop_cnt
    );

    modport slave (
        input  q, v, y_ready,
        output in_ready, y, y_valid, level, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/prio_idx_fifo.sv
// ============================================================================
// Module      : prio_idx_fifo
// Description : Small FIFO of encoded indices; full/empty come from level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_idx_fifo
    import prio_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire idx_t                   wdata,
    input  wire logic                   pop,
    output idx_t                        rdata,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    idx_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    // Storage is not reset; nothing reads it while level is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

`default_nettype wire

// File: rtl/prio_dec_2to4_buf.sv
// ============================================================================
// Module      : prio_dec_2to4_buf
// Description : Buffers encoded indices and presents their one-hot decode to
//               a valid/ready consumer; counts cycles lost to a full buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_dec_2to4_buf
    import prio_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    prio_dec_2to4_buf_if.slave    bus
);

    localparam int                 c_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);

    logic               w_push;
    logic               w_pop;
    logic               w_in_ready;
    logic               w_y_valid;
    idx_t               w_rdata;
    logic [c_LVL_W-1:0] w_level;
    logic [CNT_W-1:0]   r_drop_cnt;

    // A pop in the same cycle never frees a slot for a push when full.
    assign w_in_ready = (w_level != c_FULL) & ~rst;
    assign w_push     = bus.v & w_in_ready;
    assign w_y_valid  = (w_level != '0);
    assign w_pop      = w_y_valid & bus.y_ready;

    prio_idx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (bus.q),
        .pop   (w_pop),
        .rdata (w_rdata),
        .level (w_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (bus.v && !w_in_ready && !(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.y_valid  = w_y_valid;
    assign bus.y        = w_y_valid ? dec_idx(w_rdata) : '0;
    assign bus.level    = w_level;
    assign bus.drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prio_dec_2to4_buf.sv
// ============================================================================
// Module      : tb_prio_dec_2to4_buf
// Description : Directed bench with a scoreboard of expected y values popped
//               on each consumer handshake; a CNT_W=2 copy checks saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_dec_2to4_buf;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    prio_dec_2to4_buf_if #(.DEPTH(2), .CNT_W(8)) bus  ();
    prio_dec_2to4_buf_if #(.DEPTH(2), .CNT_W(2)) bus2 ();

    prio_dec_2to4_buf #(.DEPTH(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prio_dec_2to4_buf #(.DEPTH(2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.q       = bus.q;
    assign bus2.v       = bus.v;
    assign bus2.y_ready = bus.y_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push an index that the bench knows will be accepted on the next edge.
    task automatic push_idx(input logic [1:0] idx);
        bus.q = idx;
        bus.v = 1'b1;
        exp_q.push_back(4'b0001 << idx);
        tick();
        bus.v = 1'b0;
    endtask

    // Monitor: inputs settle 1ns after posedge, so negedge sees the handshake.
    always @(negedge clk) begin
        if (!rst && bus.y_valid && bus.y_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_pop: got y=%b with empty scoreboard", bus.y);
            end else begin
                if (bus.y !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL sb_data: got y=%b expected %b", bus.y, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.q       = 2'd0;
        bus.v       = 1'b0;
        bus.y_ready = 1'b0;

        // Reset
        tick();
        tick();
        check("in_ready_in_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_y",       32'(bus.y),       32'd0);
        check("rst_in_ready",32'(bus.in_ready),32'd1);
        check("rst_level",   32'(bus.level),   32'd0);
        check("rst_drop",    32'(bus.drop_cnt),32'd0);

        // Single entry, 1-cycle latency, then pop
        push_idx(2'd2);
        check("single_y",     32'(bus.y),       32'h4);
        check("single_valid", 32'(bus.y_valid), 32'd1);
        check("single_level", 32'(bus.level),   32'd1);
        bus.y_ready = 1'b1;
        tick();
        check("single_popped", 32'(bus.y_valid), 32'd0);
        tick();
        check("ready_empty_level", 32'(bus.level), 32'd0);
        bus.y_ready = 1'b0;

        // FIFO order and full
        push_idx(2'd3);
        push_idx(2'd0);
        check("full_level",    32'(bus.level),    32'd2);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_y",        32'(bus.y),        32'h8);
        bus.y_ready = 1'b1;
        tick();
        check("order_y",     32'(bus.y),     32'h1);
        check("order_level", 32'(bus.level), 32'd1);
        tick();
        check("order_empty", 32'(bus.y_valid), 32'd0);
        bus.y_ready = 1'b0;

        // Overflow: five dropped cycles while full and stalled
        push_idx(2'd1);
        push_idx(2'd3);
        bus.q = 2'd0;
        bus.v = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("ovf_drop",     32'(bus.drop_cnt),  32'd5);
        check("ovf_drop_sat", 32'(bus2.drop_cnt), 32'd3);
        check("ovf_level",    32'(bus.level),     32'd2);
        check("ovf_hold_y",   32'(bus.y),         32'h2);
        // Full with a pop: the push is still refused and counted
        bus.q       = 2'd2;
        bus.y_ready = 1'b1;
        tick();
        bus.v = 1'b0;
        check("fullpop_level", 32'(bus.level),     32'd1);
        check("fullpop_drop",  32'(bus.drop_cnt),  32'd6);
        check("fullpop_sat",   32'(bus2.drop_cnt), 32'd3);
        check("fullpop_y",     32'(bus.y),         32'h8);
        tick();
        check("drain_level", 32'(bus.level),    32'd0);
        check("drain_drop",  32'(bus.drop_cnt), 32'd6);
        bus.y_ready = 1'b0;

        // Concurrent push and pop at level 1
        push_idx(2'd1);
        check("conc_pre_y", 32'(bus.y), 32'h2);
        bus.q       = 2'd2;
        bus.v       = 1'b1;
        bus.y_ready = 1'b1;
        exp_q.push_back(4'b0100);
        tick();
        bus.v       = 1'b0;
        bus.y_ready = 1'b0;
        check("conc_level", 32'(bus.level), 32'd1);
        check("conc_y",     32'(bus.y),     32'h4);

        // Mid-operation reset discards everything
        push_idx(2'd3);
        check("midrst_pre_level", 32'(bus.level), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_level", 32'(bus.level),     32'd0);
        check("midrst_valid", 32'(bus.y_valid),   32'd0);
        check("midrst_drop",  32'(bus.drop_cnt),  32'd0);
        check("midrst_sat",   32'(bus2.drop_cnt), 32'd0);
        push_idx(2'd1);
        check("post_rst_y", 32'(bus.y), 32'h2);
        bus.y_ready = 1'b1;
        tick();
        bus.y_ready = 1'b0;
        check("final_empty", 32'(bus.y_valid), 32'd0);
        check("sb_drained",  32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
